// File: rtl/lut_req_server.sv
// Shared lookup-table server: many request lanes, round-robin arbitration onto
// PORTS block-RAM read ports, fixed RD_LAT read pipeline, run-time table load.
module lut_req_server #(
  parameter int LANES  = 8,
  parameter int AW     = 11,
  parameter int DW     = 11,
  parameter int PORTS  = 2,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES-1:0]    req_valid,
  input  logic [LANES*AW-1:0] req_addr,
  output logic [LANES-1:0]    req_ready,
  output logic [LANES-1:0]    rsp_valid,
  output logic [LANES*DW-1:0] rsp_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW:0] LANES_X = (LW+1)'(LANES);
  localparam int LAST = RD_LAT - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_INFLIGHT
  } lane_st_t;

  // Lane control and captured request address
  lane_st_t          lane_st_q [LANES];
  lane_st_t          lane_st_d [LANES];
  logic [AW-1:0]     addr_q    [LANES];
  logic [LANES-1:0]  req_hs;

  // Arbiter
  logic [LW-1:0]     rr_ptr_q;
  logic [LW-1:0]     rr_ptr_d;
  logic [LW:0]       arb_idx;
  int                arb_cnt;
  logic              gnt_vld   [PORTS];
  logic [LW-1:0]     gnt_lane  [PORTS];
  logic [AW-1:0]     gnt_addr  [PORTS];
  logic [LANES-1:0]  gnt_mask;

  // Table storage (no reset, block-RAM friendly)
  logic [DW-1:0]     mem [2**AW];

  // Read pipeline: stage index 0 is loaded at the grant edge
  logic              vld_p     [PORTS][RD_LAT];
  logic [LW-1:0]     lane_p    [PORTS][RD_LAT];
  logic [DW-1:0]     data_p    [PORTS][RD_LAT];

  // Pipeline exit and held response data
  logic [LANES-1:0]  exit_mask;
  logic [DW-1:0]     exit_data [LANES];
  logic [DW-1:0]     hold_q    [LANES];

  // Round-robin arbiter: first min(PORTS, pending) lanes scanning up from rr_ptr
  always_comb begin
    gnt_mask = '0;
    rr_ptr_d = rr_ptr_q;
    arb_cnt  = 0;
    arb_idx  = '0;
    for (int p = 0; p < PORTS; p++) begin
      gnt_vld[p]  = 1'b0;
      gnt_lane[p] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      // LANES need not be a power of two, so wrap with an explicit compare
      arb_idx = {1'b0, rr_ptr_q} + (LW+1)'(k);
      if (arb_idx >= LANES_X) begin
        arb_idx = arb_idx - LANES_X;
      end
      if ((lane_st_q[arb_idx[LW-1:0]] == ST_PENDING) && (arb_cnt < PORTS)) begin
        for (int p = 0; p < PORTS; p++) begin
          if (p == arb_cnt) begin
            gnt_vld[p]  = 1'b1;
            gnt_lane[p] = arb_idx[LW-1:0];
          end
        end
        gnt_mask[arb_idx[LW-1:0]] = 1'b1;
        rr_ptr_d = (arb_idx[LW-1:0] == LW'(LANES - 1)) ? '0 : arb_idx[LW-1:0] + LW'(1);
        arb_cnt  = arb_cnt + 1;
      end
    end
  end

  // Route each granted lane's captured address to its read port
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      gnt_addr[p] = addr_q[gnt_lane[p]];
    end
  end

  // Decode pipeline exits into per-lane strobes; non-exiting lanes show held data
  always_comb begin
    exit_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      exit_data[i] = hold_q[i];
    end
    for (int p = 0; p < PORTS; p++) begin
      for (int i = 0; i < LANES; i++) begin
        if (vld_p[p][LAST] && (lane_p[p][LAST] == LW'(i))) begin
          exit_mask[i] = 1'b1;
          exit_data[i] = data_p[p][LAST];
        end
      end
    end
  end

  // Lane next-state: a lane whose result exits this cycle counts as IDLE and may handshake
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_st_d[i] = lane_st_q[i];
      req_ready[i] = 1'b0;
      req_hs[i]    = 1'b0;
      case (lane_st_q[i])
        ST_IDLE: begin
          req_ready[i] = 1'b1;
          req_hs[i]    = req_valid[i];
          if (req_valid[i]) begin
            lane_st_d[i] = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (gnt_mask[i]) begin
            lane_st_d[i] = ST_INFLIGHT;
          end
        end
        ST_INFLIGHT: begin
          if (exit_mask[i]) begin
            req_ready[i] = 1'b1;
            req_hs[i]    = req_valid[i];
            lane_st_d[i] = req_valid[i] ? ST_PENDING : ST_IDLE;
          end
        end
        default: begin
          lane_st_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Lane state and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        lane_st_q[i] <= ST_IDLE;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lane_st_q[i] <= lane_st_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Capture the request address on handshake; later req_addr changes are ignored
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (req_hs[i]) begin
        addr_q[i] <= req_addr[i*AW +: AW];
      end
    end
  end

  // Table write port; reads elsewhere see the pre-write value in the same cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---- grant -> read pipeline stage 0 .. RD_LAT-1: valids (reset) ----
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (!rst_n) begin
        for (int s = 0; s < RD_LAT; s++) begin
          vld_p[p][s] <= 1'b0;
        end
      end else begin
        vld_p[p][0] <= gnt_vld[p];
        for (int s = 1; s < RD_LAT; s++) begin
          vld_p[p][s] <= vld_p[p][s-1];
        end
      end
    end
  end

  // ---- grant -> read pipeline stage 0 .. RD_LAT-1: lane tag and read data ----
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      lane_p[p][0] <= gnt_lane[p];
      if (gnt_vld[p]) begin
        data_p[p][0] <= mem[gnt_addr[p]];
      end
      for (int s = 1; s < RD_LAT; s++) begin
        lane_p[p][s] <= lane_p[p][s-1];
        data_p[p][s] <= data_p[p][s-1];
      end
    end
  end

  // ---- pipeline exit -> held response data ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!rst_n) begin
        hold_q[i] <= '0;
      end else if (exit_mask[i]) begin
        hold_q[i] <= exit_data[i];
      end
    end
  end

  // Pack per-lane responses onto the output buses
  always_comb begin
    rsp_valid = exit_mask;
    for (int i = 0; i < LANES; i++) begin
      rsp_data[i*DW +: DW] = exit_data[i];
    end
  end

endmodule

// File: tb/tb_lut_req_server.sv
// Scoreboard bench for lut_req_server: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of lanes, arbitration and table.
module tb_lut_req_server;

  localparam int LANES  = 8;
  localparam int AW     = 11;
  localparam int DW     = 11;
  localparam int PORTS  = 2;
  localparam int RD_LAT = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [LANES-1:0]    req_valid = '0;
  logic [LANES*AW-1:0] req_addr = '0;
  logic [LANES-1:0]    req_ready;
  logic [LANES-1:0]    rsp_valid;
  logic [LANES*DW-1:0] rsp_data;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [DW-1:0]       wr_data = '0;

  lut_req_server #(
    .LANES(LANES), .AW(AW), .DW(DW), .PORTS(PORTS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [DW-1:0] shadow [2**AW];
  int            m_st   [LANES];   // 0 idle, 1 waiting for a port, 2 being read
  logic [AW-1:0] m_addr [LANES];
  int            m_done [LANES];   // cycle in which the result is due
  int            m_rr = 0;
  logic [DW-1:0] exp_hold [LANES];

  typedef struct {
    int            lane;
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", nm, cyc, act, req);
    end
  endtask

  function automatic bit model_ready(input int i);
    return (m_st[i] == 0) || (m_st[i] == 2 && m_done[i] == cyc);
  endfunction

  // Behavioural model: one step per clock edge
  logic [LANES-1:0] m_rdy;
  int               m_ng;
  int               m_last;
  int               m_idx;
  initial begin
    for (int i = 0; i < LANES; i++) begin
      m_st[i] = 0;
      m_done[i] = 0;
      m_addr[i] = '0;
      exp_hold[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        m_st[i] = 0;
        exp_hold[i] = '0;
      end
      m_rr = 0;
      sb_q.delete();
    end else begin
      for (int i = 0; i < LANES; i++) m_rdy[i] = model_ready(i);
      m_ng = 0;
      m_last = -1;
      for (int k = 0; k < LANES; k++) begin
        m_idx = (m_rr + k) % LANES;
        if (m_st[m_idx] == 1 && m_ng < PORTS) begin
          sb_q.push_back('{lane: m_idx, cyc: cyc + RD_LAT, data: shadow[m_addr[m_idx]]});
          m_st[m_idx] = 2;
          m_done[m_idx] = cyc + RD_LAT;
          m_ng++;
          m_last = m_idx;
        end
      end
      if (m_last >= 0) m_rr = (m_last + 1) % LANES;
      for (int i = 0; i < LANES; i++) begin
        if (m_rdy[i]) begin
          if (req_valid[i]) begin
            m_st[i] = 1;
            m_addr[i] = req_addr[i*AW +: AW];
          end else begin
            m_st[i] = 0;
          end
        end
      end
    end
    if (wr_en) shadow[wr_addr] = wr_data;
    cyc++;
  end

  // Monitor: compares DUT outputs with the scoreboard away from the active edge
  logic [LANES-1:0] exp_rdy;
  int               mj;
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < LANES; i++) exp_rdy[i] = model_ready(i);
      chk("req_ready", req_ready, exp_rdy);
      for (int i = 0; i < LANES; i++) begin
        mj = -1;
        for (int q = 0; q < sb_q.size(); q++) begin
          if (mj < 0 && sb_q[q].lane == i) mj = q;
        end
        if (rsp_valid[i]) begin
          if (mj < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected lane %0d @cycle %0d: got valid=1 want valid=0", i, cyc);
          end else begin
            chk($sformatf("rsp_cycle lane %0d", i), cyc, sb_q[mj].cyc);
            chk($sformatf("rsp_data lane %0d", i), rsp_data[i*DW +: DW], sb_q[mj].data);
            exp_hold[i] = sb_q[mj].data;
            sb_q.delete(mj);
          end
        end else begin
          if (mj >= 0 && sb_q[mj].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing lane %0d @cycle %0d: got valid=0 want valid=1 (due %0d)", i, cyc, sb_q[mj].cyc);
            sb_q.delete(mj);
          end
          chk($sformatf("rsp_hold lane %0d", i), rsp_data[i*DW +: DW], exp_hold[i]);
        end
      end
    end
  end

  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 31) == 0) return AW'(2047);
    return AW'($urandom_range(0, 63));
  endfunction

  initial begin
    // Hard stop in case something never returns
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  int drain;

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", req_ready, 8'hFF);
    chk("reset_rsp_valid", rsp_valid, 8'h00);
    chk("reset_rsp_data", rsp_data, '0);

    // Preload table: 0..7 = 0x100+i, rest of 0..63 random, top address too
    for (int a = 0; a < 64; a++) wr(a, (a < 8) ? (32'h100 + a) : int'($urandom_range(0, 2047)));
    wr(2047, 11'h555);

    // All lanes at once with rr_ptr at 0
    req_valid = '1;
    for (int i = 0; i < LANES; i++) req_addr[i*AW +: AW] = AW'(i);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("all_lanes_valid %0d", k), rsp_valid, 8'h03 << (2 * k));
      chk("all_lanes_data_a", rsp_data[(2*k)*DW +: DW], 11'h100 + 11'(2 * k));
      chk("all_lanes_data_b", rsp_data[(2*k+1)*DW +: DW], 11'h100 + 11'(2 * k + 1));
    end
    idle(3);

    // Single-lane read
    wr(5, 11'h3A5);
    req_valid = 8'h08;
    req_addr[3*AW +: AW] = AW'(5);
    @(negedge clk);
    req_valid = '0;
    req_addr[3*AW +: AW] = AW'(6);
    chk("single_ready_c1", req_ready[3], 1'b0);
    @(negedge clk);
    chk("single_ready_c2", req_ready[3], 1'b0);
    chk("single_valid_c2", rsp_valid, 8'h00);
    @(negedge clk);
    chk("single_valid_c3", rsp_valid, 8'h08);
    chk("single_data_c3", rsp_data[3*DW +: DW], 11'h3A5);
    chk("single_ready_c3", req_ready[3], 1'b1);
    idle(3);

    // Read during write to the same address returns old data
    wr(9, 11'h011);
    req_valid = 8'h02;
    req_addr[1*AW +: AW] = AW'(9);
    @(negedge clk);
    req_valid = '0;
    wr_en = 1'b1;
    wr_addr = AW'(9);
    wr_data = 11'h7FF;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk("rdw_old_valid", rsp_valid, 8'h02);
    chk("rdw_old_data", rsp_data[1*DW +: DW], 11'h011);
    req_valid = 8'h02;
    @(negedge clk);
    req_valid = '0;
    idle(2);
    chk("rdw_new_data", rsp_data[1*DW +: DW], 11'h7FF);
    idle(2);

    // Reset with four lanes in flight
    req_valid = 8'h0F;
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = AW'(10 + i);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_ready", req_ready, 8'hFF);
    chk("midreset_rsp_data", rsp_data, '0);
    for (int k = 0; k < 10; k++) begin
      chk("midreset_no_valid", rsp_valid, 8'h00);
      @(negedge clk);
    end
    req_valid = 8'h20;
    req_addr[5*AW +: AW] = AW'(2047);
    @(negedge clk);
    req_valid = '0;
    idle(2);
    chk("postreset_valid", rsp_valid, 8'h20);
    chk("postreset_data", rsp_data[5*DW +: DW], 11'h555);
    idle(2);

    // Back-to-back throughput on lane 0
    req_valid = 8'h01;
    req_addr[0 +: AW] = AW'(20);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 12) req_valid = '0;
      chk($sformatf("b2b_valid k=%0d", k), rsp_valid[0],
          ((k % 3 == 0) && (k >= 3) && (k <= 12)) ? 1'b1 : 1'b0);
    end
    idle(2);

    // Randomized traffic with colliding writes and occasional reset
    for (int n = 0; n < 1500; n++) begin
      req_valid = LANES'($urandom);
      for (int i = 0; i < LANES; i++) req_addr[i*AW +: AW] = pick_addr();
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = pick_addr();
      wr_data = DW'($urandom);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      @(negedge clk);
    end
    req_valid = '0;
    wr_en = 1'b0;
    rst_n = 1'b1;

    // Drain outstanding responses within a bounded number of cycles
    drain = 0;
    while (sb_q.size() != 0 && drain < 50) begin
      @(negedge clk);
      drain++;
    end
    chk("drain_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
